// File: rtl/axi4_stream_fifo_pipe_pkg.sv
// Shared AXI4-Stream field widths, the packed payload type and its pack/unpack helpers.
package stl_axis_pkg;

  localparam int TDATA_W = 8;
  localparam int TSTRB_W = TDATA_W / 8;
  localparam int TKEEP_W = TDATA_W / 8;
  localparam int TID_W   = 2;
  localparam int TDEST_W = 2;
  localparam int TUSER_W = 2;
  localparam int T_TTW   = TDATA_W + TSTRB_W + TKEEP_W + 1 + TID_W + TDEST_W + TUSER_W;

  typedef logic [T_TTW-1:0] axis_payload_t;

  // Field order matches the payload vector: tdata in the MSBs down to tuser in the LSBs.
  typedef struct packed {
    logic [TDATA_W-1:0] tdata;
    logic [TSTRB_W-1:0] tstrb;
    logic [TKEEP_W-1:0] tkeep;
    logic               tlast;
    logic [TID_W-1:0]   tid;
    logic [TDEST_W-1:0] tdest;
    logic [TUSER_W-1:0] tuser;
  } axis_beat_t;

  function automatic axis_payload_t axis_pack(
    input logic [TDATA_W-1:0] tdata,
    input logic [TSTRB_W-1:0] tstrb,
    input logic [TKEEP_W-1:0] tkeep,
    input logic               tlast,
    input logic [TID_W-1:0]   tid,
    input logic [TDEST_W-1:0] tdest,
    input logic [TUSER_W-1:0] tuser
  );
    return {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
  endfunction

  function automatic axis_beat_t axis_unpack(input axis_payload_t p);
    return axis_beat_t'(p);
  endfunction

  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle using the field widths from stl_axis_pkg.
interface axi4_stream_if;
  import stl_axis_pkg::*;

  logic               tvalid;
  logic               tready;
  logic [TDATA_W-1:0] tdata;
  logic [TSTRB_W-1:0] tstrb;
  logic [TKEEP_W-1:0] tkeep;
  logic               tlast;
  logic [TID_W-1:0]   tid;
  logic [TDEST_W-1:0] tdest;
  logic [TUSER_W-1:0] tuser;

  modport Master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
  modport Slave  (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);

endinterface

// File: rtl/axi4_stream_fifo_pipe_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module StlFifoRam #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/axi4_stream_fifo_pipe.sv
// DEPTH-entry AXI4-Stream FIFO with level and packet-count outputs.
// Define AXIS_FIFO_PIPE_PKT_MODE_EN for store-and-forward (whole-packet) release.
module axi4_stream_fifo_pipe
  import stl_axis_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  axi4_stream_if.Slave     axi_if_i,
  axi4_stream_if.Master    axi_if_o,
  output logic [LVL_W-1:0] level_o,
  output logic [LVL_W-1:0] pkt_cnt_o
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL  = LVL_W'(DEPTH);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] r_pkt;
  logic             r_run;

  logic          w_tready;
  logic          w_tvalid;
  logic          w_push;
  logic          w_pop;
  logic          w_push_last;
  logic          w_pop_last;
  axis_payload_t w_wdata;
  axis_payload_t w_rdata;
  axis_beat_t    w_head;
  axis_beat_t    w_out;

  // r_run holds tready low while in reset and releases it on the first edge afterwards.
  assign w_tready = r_run && (r_level != FULL);

`ifdef AXIS_FIFO_PIPE_PKT_MODE_EN
  // A full FIFO releases beats even without a complete packet so long packets cannot deadlock.
  assign w_tvalid = (r_pkt != '0) || (r_level == FULL);
`else
  assign w_tvalid = (r_level != '0);
`endif

  assign w_push      = axi_if_i.tvalid && w_tready;
  assign w_pop       = w_tvalid && axi_if_o.tready;
  assign w_push_last = w_push && axi_if_i.tlast;
  assign w_pop_last  = w_pop && w_head.tlast;

  assign w_wdata = axis_pack(axi_if_i.tdata, axi_if_i.tstrb, axi_if_i.tkeep, axi_if_i.tlast,
                             axi_if_i.tid, axi_if_i.tdest, axi_if_i.tuser);
  assign w_head  = axis_unpack(w_rdata);

  StlFifoRam #(
    .DEPTH (DEPTH),
    .WIDTH (T_TTW)
  ) u_ram (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wptr),
    .wdata (w_wdata),
    .raddr (r_rptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_pkt   <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      case ({w_push_last, w_pop_last})
        2'b10:   r_pkt <= r_pkt + 1'b1;
        2'b01:   r_pkt <= r_pkt - 1'b1;
        default: r_pkt <= r_pkt;
      endcase
    end
  end

  // Payload is zeroed whenever no beat is offered downstream.
  assign w_out = w_tvalid ? w_head : '0;

  assign axi_if_i.tready = w_tready;
  assign axi_if_o.tvalid = w_tvalid;
  assign axi_if_o.tdata  = w_out.tdata;
  assign axi_if_o.tstrb  = w_out.tstrb;
  assign axi_if_o.tkeep  = w_out.tkeep;
  assign axi_if_o.tlast  = w_out.tlast;
  assign axi_if_o.tid    = w_out.tid;
  assign axi_if_o.tdest  = w_out.tdest;
  assign axi_if_o.tuser  = w_out.tuser;
  assign level_o         = r_level;
  assign pkt_cnt_o       = r_pkt;

endmodule

// File: doc/axi4_stream_fifo_pipe.md
# axi4_stream_fifo_pipe

Parametrised AXI4-Stream buffering stage that replaces a single register slice with a DEPTH-entry synchronous FIFO. All sideband fields (tdata, tstrb, tkeep, tlast, tid, tdest, tuser) are carried as one packed payload. The block adds fill-level and packet-count visibility, plus an optional store-and-forward packet mode. It sits between stream producers and consumers wherever elastic buffering or whole-packet release is needed.

## Interface
Parameters:
- DEPTH, 4: number of payload entries; power of two, ≥ 2.
- LVL_W, $clog2(DEPTH)+1: width of the level and count outputs (derived; never overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- axi_if_i  axi4_stream_if.Slave  —  upstream stream; the block drives tready.
- axi_if_o  axi4_stream_if.Master  —  downstream stream; the block drives tvalid and all payload fields.
- level_o  output  LVL_W  number of occupied entries, 0..DEPTH.
- pkt_cnt_o  output  LVL_W  number of stored beats with tlast=1, 0..DEPTH.

## Operation
- Payload width T_TTW is the sum of $bits of tdata, tstrb, tkeep, tlast, tid, tdest and tuser. Packing order is tdata (MSB) down to tuser (LSB).
- Push occurs when axi_if_i.tvalid && axi_if_i.tready.
- Pop occurs when axi_if_o.tvalid && axi_if_o.tready.
- Pointers are log2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- level register:
  - +1 on push only; −1 on pop only.
  - Unchanged on simultaneous push and pop.
- axi_if_i.tready = (level != DEPTH), registered state only. There is no combinational path from axi_if_o.tready. When full, a same-cycle pop does not enable a push.
- axi_if_o.tvalid = (level != 0) in cut-through mode. See Configuration for packet mode.
- Payload outputs:
  - Driven from the head entry when axi_if_o.tvalid = 1.
  - Forced to all-zero when tvalid = 0.
- Payload on axi_if_o is stable while tvalid && !tready, per AXI4-Stream.
- pkt_cnt register:
  - +1 on a push whose tlast = 1; −1 on a pop whose tlast = 1.
  - Net 0 when both happen in the same cycle.
- Storage array is not reset.

## Timing
- Reset (rst_n low, asynchronous): axi_if_i.tready = 0, axi_if_o.tvalid = 0, payload outputs = 0, level_o = 0, pkt_cnt_o = 0, pointers = 0.
- First cycle after rst_n rises: tready = 1.
- Latency: a beat pushed at edge N is presented on axi_if_o after edge N (cut-through, empty FIFO), i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained for any DEPTH ≥ 2 when the downstream is always ready.
- level_o and pkt_cnt_o are registered and reflect pushes and pops up to the previous edge.
- Reset asserted mid-packet discards all contents. No partial packet survives reset.

## Configuration
- Macro AXIS_FIFO_PIPE_PKT_MODE_EN.
- Defined (store-and-forward packet mode):
  - axi_if_o.tvalid = (pkt_cnt != 0) || (level == DEPTH).
  - The full-FIFO override is a forced release that prevents deadlock on packets longer than DEPTH. Once forced, beats drain until the FIFO is no longer full, then gating resumes.
  - Latency to the first output beat = 1 cycle after the tlast beat is pushed.
- Undefined: cut-through. tvalid = (level != 0). pkt_cnt_o is still maintained.

## Structure
- Package stl_axis_pkg holds:
  - the axis_payload_t packing function pair (pack/unpack between interface fields and a T_TTW vector);
  - a clog2-based LVL_W helper constant function.
- Sub-module StlFifoRam holds the DEPTH × T_TTW storage:
  - one write port (we, waddr, wdata);
  - one asynchronous read port (raddr, rdata);
  - no reset.
- Top level holds pointers, level and pkt_cnt counters, and output gating.

## Test plan
- Reset and single beat:
  - Reset, then push one beat tdata=0xA5, tlast=1 with downstream ready → axi_if_o.tvalid rises 1 cycle later with tdata=0xA5.
  - level_o shows 1 for one cycle, then returns to 0.
- Fill and backpressure (DEPTH=4, downstream tready=0):
  - Push beats 1..4 → tready drops after the 4th push and level_o = 4.
  - A 5th beat is held upstream. Releasing tready drains 1,2,3,4 in order.
- Simultaneous push/pop at level 2 for 10 cycles → level_o stays 2 and output order is preserved.
- Pointer wrap: stream 20 incrementing beats with random downstream stalls → output sequence 0..19 is intact.
- Packet mode (macro defined):
  - Push a 3-beat packet with tlast on beat 3 → axi_if_o.tvalid stays 0 until 1 cycle after beat 3 is pushed, then 3 beats emerge.
  - A 6-beat packet into DEPTH=4 → forced release at full, and all 6 beats are delivered.
- Reset mid-packet: assert rst_n low after 2 of 3 beats are pushed → all outputs reach their reset values immediately. After release, level_o = 0 and no stale beat is emitted.
